// File: rtl/dsnk_pkg.sv
// Shared definitions for the multi-channel AXI-Stream data sink: command codes,
// channel state encoding and the strobe helper functions.
package dsnk_pkg;

   typedef enum logic [1:0] {
      OP_NOP   = 2'd0,
      OP_START = 2'd1,
      OP_STOP  = 2'd2,
      OP_CLEAR = 2'd3
   } dsnk_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } dsnk_state_e;

   localparam int unsigned MaxBytes = 32;

   // Callers zero-extend narrower strobes, so unused bits contribute nothing.
   function automatic logic [5:0] popcount(input logic [MaxBytes-1:0] strb);
      logic [5:0] cnt;
      cnt = '0;
      for (int i = 0; i < MaxBytes; i++) begin
         cnt = cnt + 6'(strb[i]);
      end
      return cnt;
   endfunction

   function automatic logic [MaxBytes*8-1:0] masked_data(input logic [MaxBytes*8-1:0] data,
                                                        input logic [MaxBytes-1:0]   strb);
      logic [MaxBytes*8-1:0] res;
      res = '0;
      for (int i = 0; i < MaxBytes; i++) begin
         if (strb[i]) res[i*8 +: 8] = data[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/axis_dsnk_chan.sv
// One sink channel: IDLE/RUN/DONE control, strobe-aware byte and packet counters
// and a 64-bit additive checksum of the accepted data.
module axis_dsnk_chan
   import dsnk_pkg::*;
#(
   parameter int unsigned NumBytes = 4,
   parameter int unsigned CntWidth = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  tvalid_i,
   output logic                  tready_o,
   input  logic [NumBytes*8-1:0] tdata_i,
   input  logic [NumBytes-1:0]   tstrb_i,
   input  logic                  tlast_i,
   input  logic                  start_i,
   input  logic                  stop_i,
   input  logic                  clear_i,
   input  logic                  stop_on_last_i,
   input  logic [CntWidth-1:0]   limit_i,
   output dsnk_state_e           state_o,
   output logic [CntWidth-1:0]   bytes_o,
   output logic [CntWidth-1:0]   pkts_o,
   output logic [63:0]           checksum_o
);

   dsnk_state_e         state_q, state_d;
   logic [CntWidth-1:0] bytes_q, bytes_d, pkts_q, pkts_d, limit_q, limit_d;
   logic [63:0]         csum_q, csum_d;
   logic                sol_q, sol_d;

   logic                  accept;
   logic [CntWidth-1:0]   bytes_next;
   logic [MaxBytes*8-1:0] data_masked;

   assign accept      = tvalid_i && (state_q == ST_RUN);
   assign bytes_next  = bytes_q + CntWidth'(popcount(MaxBytes'(tstrb_i)));
   assign data_masked = masked_data((MaxBytes*8)'(tdata_i), MaxBytes'(tstrb_i));

   always_comb begin
      state_d = state_q;
      bytes_d = bytes_q;
      pkts_d  = pkts_q;
      csum_d  = csum_q;
      limit_d = limit_q;
      sol_d   = sol_q;
      if (clear_i) begin
         // Clear dominates; a beat accepted this cycle is dropped uncounted.
         state_d = ST_IDLE;
         bytes_d = '0;
         pkts_d  = '0;
         csum_d  = '0;
      end else begin
         if (accept) begin
            bytes_d = bytes_next;
            pkts_d  = pkts_q + CntWidth'(tlast_i);
            csum_d  = csum_q + data_masked[63:0];
         end
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_i) begin
                  state_d = ST_RUN;
                  limit_d = limit_i;
                  sol_d   = stop_on_last_i;
               end
            end
            ST_RUN: begin
               if (stop_i ||
                   (accept && (limit_q != '0) && (bytes_next >= limit_q)) ||
                   (accept && sol_q && tlast_i)) begin
                  state_d = ST_DONE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         bytes_q <= '0;
         pkts_q  <= '0;
         csum_q  <= '0;
         limit_q <= '0;
         sol_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bytes_q <= bytes_d;
         pkts_q  <= pkts_d;
         csum_q  <= csum_d;
         limit_q <= limit_d;
         sol_q   <= sol_d;
      end
   end

   assign tready_o   = (state_q == ST_RUN);
   assign state_o    = state_q;
   assign bytes_o    = bytes_q;
   assign pkts_o     = pkts_q;
   assign checksum_o = csum_q;

endmodule

// File: rtl/axis_dsnk_mc.sv
// Multi-channel AXI-Stream sink: NUM_CHAN independent channels, a decoded command
// port and a registered per-channel status read port.
module axis_dsnk_mc
   import dsnk_pkg::*;
#(
   parameter int unsigned NUM_CHAN                 = 4,
   parameter int unsigned C_S_AXIS_TDATA_NUM_BYTES = 4,
   parameter int unsigned CNT_WIDTH                = 32,
   localparam int unsigned ChanW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1,
   localparam int unsigned NB    = C_S_AXIS_TDATA_NUM_BYTES
) (
   input  logic                       AXIS_ACLK,
   input  logic                       AXIS_ARESETN,
   input  logic [NUM_CHAN-1:0]        S_AXIS_TVALID,
   output logic [NUM_CHAN-1:0]        S_AXIS_TREADY,
   input  logic [NUM_CHAN*NB*8-1:0]   S_AXIS_TDATA,
   input  logic [NUM_CHAN*NB-1:0]     S_AXIS_TSTRB,
   input  logic [NUM_CHAN-1:0]        S_AXIS_TLAST,
   input  logic                       cmd_valid,
   input  logic [ChanW-1:0]           cmd_chan,
   input  logic [1:0]                 cmd_op,
   input  logic                       cmd_stop_on_last,
   input  logic [CNT_WIDTH-1:0]       cmd_limit,
   input  logic [ChanW-1:0]           rd_chan,
   output logic [CNT_WIDTH-1:0]       rd_bytes,
   output logic [CNT_WIDTH-1:0]       rd_pkts,
   output logic [63:0]                rd_checksum,
   output logic [1:0]                 rd_state,
   output logic [NUM_CHAN-1:0]        done
);

   dsnk_state_e          ch_state [NUM_CHAN];
   logic [CNT_WIDTH-1:0] ch_bytes [NUM_CHAN];
   logic [CNT_WIDTH-1:0] ch_pkts  [NUM_CHAN];
   logic [63:0]          ch_csum  [NUM_CHAN];

   for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
      logic hit;
      assign hit = cmd_valid && (cmd_chan == ChanW'(c));

      axis_dsnk_chan #(
         .NumBytes (NB),
         .CntWidth (CNT_WIDTH)
      ) u_chan (
         .clk_i          (AXIS_ACLK),
         .rst_ni         (AXIS_ARESETN),
         .tvalid_i       (S_AXIS_TVALID[c]),
         .tready_o       (S_AXIS_TREADY[c]),
         .tdata_i        (S_AXIS_TDATA[c*NB*8 +: NB*8]),
         .tstrb_i        (S_AXIS_TSTRB[c*NB +: NB]),
         .tlast_i        (S_AXIS_TLAST[c]),
         .start_i        (hit && (cmd_op == OP_START)),
         .stop_i         (hit && (cmd_op == OP_STOP)),
         .clear_i        (hit && (cmd_op == OP_CLEAR)),
         .stop_on_last_i (cmd_stop_on_last),
         .limit_i        (cmd_limit),
         .state_o        (ch_state[c]),
         .bytes_o        (ch_bytes[c]),
         .pkts_o         (ch_pkts[c]),
         .checksum_o     (ch_csum[c])
      );

      assign done[c] = (ch_state[c] == ST_DONE);
   end

   logic [CNT_WIDTH-1:0] bytes_d, pkts_d;
   logic [63:0]          csum_d;
   logic [1:0]           state_d;

   // An out-of-range rd_chan reads back as all zeros.
   always_comb begin
      bytes_d = '0;
      pkts_d  = '0;
      csum_d  = '0;
      state_d = ST_IDLE;
      for (int c = 0; c < NUM_CHAN; c++) begin
         if (rd_chan == ChanW'(c)) begin
            bytes_d = ch_bytes[c];
            pkts_d  = ch_pkts[c];
            csum_d  = ch_csum[c];
            state_d = ch_state[c];
         end
      end
   end

   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         rd_bytes    <= '0;
         rd_pkts     <= '0;
         rd_checksum <= '0;
         rd_state    <= ST_IDLE;
      end else begin
         rd_bytes    <= bytes_d;
         rd_pkts     <= pkts_d;
         rd_checksum <= csum_d;
         rd_state    <= state_d;
      end
   end

endmodule
